// File: rtl/rca_share_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder among NUM_REQ requesters.
// Latency: accept edge T, result latched at T+1; one transaction in flight, min accept spacing 3 cycles.
// Backpressure: o_req_ready stays low until the tagged response is taken via i_rsp_ready.

// Plain ripple-carry adder: WIDTH full-adder cells, carry-in tied low, carry out as MSB.
module rca_10bit #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH:0]   o_sum
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
      assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end
  endgenerate

  assign o_sum[WIDTH] = w_c[WIDTH];

endmodule

module rca_share_arbiter #(
  parameter int WIDTH   = 10,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_op1,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_op2,
  output logic                     o_rsp_valid,
  output logic [ID_W-1:0]          o_rsp_id,
  output logic [WIDTH:0]           o_rsp_result,
  input  logic                     i_rsp_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_gid;
  logic [WIDTH-1:0]   r_op1;
  logic [WIDTH-1:0]   r_op2;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [WIDTH:0]     r_rsp_result;

  logic               w_gnt_vld;
  logic [ID_W-1:0]    w_gnt_id;
  logic [ID_W-1:0]    w_idx;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_accept;
  logic               w_done;
  logic [WIDTH:0]     w_sum;

  // Round-robin search starting at r_rr_ptr; descending loop so the nearest offset wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_idx     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = r_rr_ptr + ID_W'(i);
      if (i_req_valid[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_idx;
      end
    end
  end

  // FSM next-state and per-state strobes; ready is only offered from IDLE.
  always_comb begin
    w_next      = r_state;
    w_req_ready = '0;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_req_ready[w_gnt_id] = 1'b1;
          w_accept              = 1'b1;
          w_next                = S_CALC;
        end
      end
      S_CALC: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Adder sees only the captured operands, so requester changes after accept are harmless.
  rca_10bit #(
    .WIDTH (WIDTH)
  ) u_rca (
    .i_a   (r_op1),
    .i_b   (r_op2),
    .o_sum (w_sum)
  );

  // Operand capture, result latch, response hold and pointer advance on completion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr     <= '0;
      r_gid        <= '0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
    end else begin
      if (w_accept) begin
        r_op1 <= i_req_op1[w_gnt_id*WIDTH +: WIDTH];
        r_op2 <= i_req_op2[w_gnt_id*WIDTH +: WIDTH];
        r_gid <= w_gnt_id;
      end
      if (r_state == S_CALC) begin
        r_rsp_result <= w_sum;
        r_rsp_id     <= r_gid;
        r_rsp_valid  <= 1'b1;
      end
      if (w_done) begin
        r_rsp_valid <= 1'b0;
        r_rr_ptr    <= r_gid + 1'b1;
      end
    end
  end

  assign o_req_ready  = i_rst ? '0 : w_req_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_rsp_result;

endmodule

// File: tb/tb_rca_share_arbiter.sv
// Directed bench for rca_share_arbiter: single op, carry, fairness, backpressure,
// skip/wrap and mid-operation reset, with hand-computed expectations.
module tb_rca_share_arbiter;

  localparam int WIDTH   = 10;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                     i_clk;
  logic                     i_rst;
  logic [NUM_REQ-1:0]       i_req_valid;
  logic [NUM_REQ-1:0]       o_req_ready;
  logic [NUM_REQ*WIDTH-1:0] i_req_op1;
  logic [NUM_REQ*WIDTH-1:0] i_req_op2;
  logic                     o_rsp_valid;
  logic [ID_W-1:0]          o_rsp_id;
  logic [WIDTH:0]           o_rsp_result;
  logic                     i_rsp_ready;

  int n_checks;
  int n_fail;
  int cyc;
  int last_acc;

  rca_share_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_op1    (i_req_op1),
    .i_req_op2    (i_req_op2),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_result (o_rsp_result),
    .i_rsp_ready  (i_rsp_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic set_ops(input int k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    i_req_op1[k*WIDTH +: WIDTH] = a;
    i_req_op2[k*WIDTH +: WIDTH] = b;
  endtask

  task automatic check_rsp(input string tag, input int id, input int res);
    check_eq({tag, "_vld"}, 32'(o_rsp_valid), 32'd1);
    check_eq({tag, "_id"},  32'(o_rsp_id), 32'(id));
    check_eq({tag, "_res"}, 32'(o_rsp_result), 32'(res));
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    cyc         = 0;
    last_acc    = 0;
    i_rst       = 1'b1;
    i_req_valid = '0;
    i_req_op1   = '0;
    i_req_op2   = '0;
    i_rsp_ready = 1'b1;
    tick();
    tick();

    // Reset state; ready must stay low under reset even with valids present.
    i_req_valid = 4'b1111;
    #1;
    check_eq("rst_ready", 32'(o_req_ready), 32'd0);
    check_eq("rst_vld",   32'(o_rsp_valid), 32'd0);
    check_eq("rst_id",    32'(o_rsp_id), 32'd0);
    check_eq("rst_res",   32'(o_rsp_result), 32'd0);
    i_req_valid = '0;
    i_rst = 1'b0;
    tick();

    // Single request from requester 2: 0x155 + 0x0AB = 0x200.
    set_ops(2, 10'h155, 10'h0AB);
    i_req_valid = 4'b0100;
    #1;
    check_eq("single_ready", 32'(o_req_ready), 32'b0100);
    tick();
    i_req_valid = '0;
    set_ops(2, 10'h3FF, 10'h3FF);
    #1;
    check_eq("single_calc_ready", 32'(o_req_ready), 32'd0);
    check_eq("single_calc_vld", 32'(o_rsp_valid), 32'd0);
    tick();
    check_rsp("single", 2, 'h200);
    tick();
    check_eq("single_done_vld", 32'(o_rsp_valid), 32'd0);

    // Carry out from requester 0 (rr_ptr now 3, wraps to 0).
    set_ops(0, 10'h3FF, 10'h3FF);
    i_req_valid = 4'b0001;
    #1;
    check_eq("carry1_ready", 32'(o_req_ready), 32'b0001);
    tick();
    i_req_valid = '0;
    tick();
    check_rsp("carry1", 0, 'h7FE);
    tick();
    set_ops(0, 10'h3FF, 10'h001);
    i_req_valid = 4'b0001;
    #1;
    check_eq("carry2_ready", 32'(o_req_ready), 32'b0001);
    tick();
    i_req_valid = '0;
    set_ops(0, 10'h000, 10'h000);
    tick();
    check_rsp("carry2", 0, 'h400);
    tick();

    // Fairness: all valids held from reset, grants 0,1,2,3,0,1 exactly 3 cycles apart.
    for (int k = 0; k < NUM_REQ; k++) set_ops(k, 10'(16*k + 5), 10'(3*k + 300));
    i_rst = 1'b1;
    i_req_valid = 4'b1111;
    tick();
    i_rst = 1'b0;
    #1;
    for (int n = 0; n < 6; n++) begin
      int g;
      g = n % NUM_REQ;
      check_eq($sformatf("fair_ready%0d", n), 32'(o_req_ready), 32'(1 << g));
      if (n > 0) check_eq($sformatf("fair_gap%0d", n), 32'(cyc - last_acc), 32'd3);
      last_acc = cyc;
      tick();
      tick();
      check_rsp($sformatf("fair%0d", n), g, (16*g + 5) + (3*g + 300));
      tick();
    end
    i_req_valid = '0;

    // Backpressure: response held 5 cycles; requester 1 waits. rr_ptr is 2 here.
    i_rsp_ready = 1'b0;
    set_ops(2, 10'h0F0, 10'h00F);
    set_ops(1, 10'h100, 10'h023);
    i_req_valid = 4'b0100;
    #1;
    check_eq("bp_ready", 32'(o_req_ready), 32'b0100);
    tick();
    i_req_valid = 4'b0010;
    #1;
    check_eq("bp_calc_ready", 32'(o_req_ready), 32'd0);
    tick();
    for (int n = 0; n < 5; n++) begin
      check_rsp($sformatf("bp_hold%0d", n), 2, 'h0FF);
      check_eq($sformatf("bp_hold_ready%0d", n), 32'(o_req_ready), 32'd0);
      tick();
    end
    i_rsp_ready = 1'b1;
    #1;
    check_eq("bp_last_ready", 32'(o_req_ready), 32'd0);
    tick();
    check_eq("bp_grant1", 32'(o_req_ready), 32'b0010);
    tick();
    i_req_valid = '0;
    tick();
    check_rsp("bp_r1", 1, 'h123);
    tick();

    // Move rr_ptr to 3 with a lone requester-2 transaction.
    set_ops(2, 10'h001, 10'h001);
    i_req_valid = 4'b0100;
    #1;
    check_eq("pre_wrap_ready", 32'(o_req_ready), 32'b0100);
    tick();
    i_req_valid = '0;
    tick();
    check_rsp("pre_wrap", 2, 'h002);
    tick();

    // Skip and wrap: only 1 and 3 valid, rr_ptr=3 -> grant 3 then 1.
    set_ops(3, 10'h200, 10'h1FF);
    set_ops(1, 10'h010, 10'h020);
    i_req_valid = 4'b1010;
    #1;
    check_eq("wrap_ready3", 32'(o_req_ready), 32'b1000);
    tick();
    i_req_valid = 4'b0010;
    #1;
    check_eq("wrap_calc_ready", 32'(o_req_ready), 32'd0);
    tick();
    check_rsp("wrap3", 3, 'h3FF);
    tick();
    check_eq("wrap_ready1", 32'(o_req_ready), 32'b0010);
    tick();
    i_req_valid = '0;
    tick();
    check_rsp("wrap1", 1, 'h030);
    tick();

    // Reset during CALC: transaction dropped, rr_ptr back to 0.
    set_ops(3, 10'h111, 10'h222);
    i_req_valid = 4'b1000;
    #1;
    check_eq("mrst_ready", 32'(o_req_ready), 32'b1000);
    tick();
    i_req_valid = '0;
    i_rst = 1'b1;
    #1;
    check_eq("mrst_ready_hi", 32'(o_req_ready), 32'd0);
    tick();
    check_eq("mrst_vld", 32'(o_rsp_valid), 32'd0);
    check_eq("mrst_id",  32'(o_rsp_id), 32'd0);
    check_eq("mrst_res", 32'(o_rsp_result), 32'd0);
    i_rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      check_eq($sformatf("mrst_novld%0d", n), 32'(o_rsp_valid), 32'd0);
    end
    set_ops(0, 10'h0AA, 10'h055);
    i_req_valid = 4'b0111;
    #1;
    check_eq("mrst_grant0", 32'(o_req_ready), 32'b0001);
    tick();
    i_req_valid = '0;
    tick();
    check_rsp("mrst_r0", 0, 'h0FF);
    tick();
    check_eq("mrst_done_vld", 32'(o_rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
